// File: rtl/keypad_grid_capture.sv
// keypad_grid_capture: turns scanner key presses into a 3x3 drawing grid.
// Each physical press is accepted once, after a debounce hold and before a
// release timeout. Keys 1-9 toggle pixels, '*' clears the grid and '#' hands
// a snapshot of the grid to the downstream classifier on a valid/ready link.
module keypad_grid_capture #(
  parameter int HOLD_CYCLES    = 1000,
  parameter int RELEASE_CYCLES = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_code,
  input  logic        key_valid,
  input  logic        frame_ready,
  output logic [8:0]  grid,
  output logic [8:0]  frame,
  output logic        frame_valid,
  output logic        key_event,
  output logic [3:0]  key_idx,
  output logic        overrun
);

  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] RELEASE_LAST = 16'(RELEASE_CYCLES - 1);

  localparam int KEY_STAR = 9;
  localparam int KEY_HASH = 11;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] code_s1_q, code_s1_d;
  logic [11:0] code_s2_q, code_s2_d;
  logic        valid_s1_q, valid_s1_d;
  logic        valid_s2_q, valid_s2_d;
  logic [11:0] code_q, code_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] rel_cnt_q, rel_cnt_d;
  logic [8:0]  grid_q, grid_d;
  logic [8:0]  frame_q, frame_d;
  logic        frame_valid_q, frame_valid_d;
  logic        key_event_q, key_event_d;
  logic [3:0]  key_idx_q, key_idx_d;
  logic        overrun_q, overrun_d;
  logic        accept;

  // Position of the single set bit of a one-hot key code.
  function automatic logic [3:0] onehot_index(input logic [11:0] code);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (code[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Next-state logic: synchronizer shift, press qualification FSM, key
  // actions and the frame handshake.
  always_comb begin
    valid_s1_d    = key_valid;
    valid_s2_d    = valid_s1_q;
    code_s1_d     = key_code;
    code_s2_d     = code_s1_q;
    state_d       = state_q;
    code_d        = code_q;
    cnt_d         = cnt_q;
    rel_cnt_d     = rel_cnt_q;
    grid_d        = grid_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    key_event_d   = 1'b0;
    key_idx_d     = key_idx_q;
    overrun_d     = overrun_q;
    accept        = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_s2_q && ($countones(code_s2_q) == 1)) begin
          code_d    = code_s2_q;
          cnt_d     = 16'd0;
          rel_cnt_d = 16'd0;
          state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (valid_s2_q && (code_s2_q == code_q)) begin
          if (cnt_q == HOLD_LAST) begin
            accept    = 1'b1;
            cnt_d     = 16'd0;
            rel_cnt_d = 16'd0;
            state_d   = HELD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d   = 16'd0;
          state_d = IDLE;
        end
      end
      HELD: begin
        if (valid_s2_q) begin
          rel_cnt_d = 16'd0;
        end else if (rel_cnt_q == RELEASE_LAST) begin
          rel_cnt_d = 16'd0;
          cnt_d     = 16'd0;
          state_d   = IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    if (accept) begin
      key_event_d = 1'b1;
      key_idx_d   = onehot_index(code_q);
      grid_d      = grid_q ^ code_q[8:0];
      if (code_q[KEY_STAR]) begin
        grid_d = 9'd0;
      end
      if (code_q[KEY_HASH]) begin
        if (!frame_valid_q || frame_ready) begin
          frame_d       = grid_q;
          frame_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  // State registers, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      code_s1_q     <= 12'd0;
      code_s2_q     <= 12'd0;
      valid_s1_q    <= 1'b0;
      valid_s2_q    <= 1'b0;
      code_q        <= 12'd0;
      cnt_q         <= 16'd0;
      rel_cnt_q     <= 16'd0;
      grid_q        <= 9'd0;
      frame_q       <= 9'd0;
      frame_valid_q <= 1'b0;
      key_event_q   <= 1'b0;
      key_idx_q     <= 4'd0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_s1_q     <= code_s1_d;
      code_s2_q     <= code_s2_d;
      valid_s1_q    <= valid_s1_d;
      valid_s2_q    <= valid_s2_d;
      code_q        <= code_d;
      cnt_q         <= cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      grid_q        <= grid_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      key_event_q   <= key_event_d;
      key_idx_q     <= key_idx_d;
      overrun_q     <= overrun_d;
    end
  end

  assign grid        = grid_q;
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign key_event   = key_event_q;
  assign key_idx     = key_idx_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_keypad_grid_capture.sv
// tb_keypad_grid_capture: scenario tasks plus randomized presses checked
// against a press-level model of the grid, frame and overrun behaviour.
module tb_keypad_grid_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] key_code = 12'd0;
  logic        key_valid = 1'b0;
  logic        frame_ready = 1'b0;
  logic [8:0]  grid;
  logic [8:0]  frame;
  logic        frame_valid;
  logic        key_event;
  logic [3:0]  key_idx;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int ev_cnt = 0;

  // Expected state, updated once per accepted press
  logic [8:0] m_grid = 9'd0;
  logic [8:0] m_frame = 9'd0;
  logic       m_fv = 1'b0;
  logic       m_ovr = 1'b0;
  logic [3:0] m_idx = 4'd0;

  keypad_grid_capture #(
    .HOLD_CYCLES(4),
    .RELEASE_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_code(key_code),
    .key_valid(key_valid),
    .frame_ready(frame_ready),
    .grid(grid),
    .frame(frame),
    .frame_valid(frame_valid),
    .key_event(key_event),
    .key_idx(key_idx),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // key_event lasts exactly one cycle, so one negedge sample per pulse
  always @(negedge clk) begin
    if (key_event) ev_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Effect of one accepted key: 1-9 toggle, '*' clears, '#' submits or overruns
  function automatic void model_key(input int idx, input bit rdy);
    m_idx = 4'(idx);
    if (idx < 9) m_grid[idx] = ~m_grid[idx];
    else if (idx == 9) m_grid = 9'd0;
    else if (idx == 11) begin
      if (!m_fv || rdy) begin
        m_frame = m_grid;
        m_fv = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endfunction

  function automatic void model_reset();
    m_grid = 9'd0;
    m_frame = 9'd0;
    m_fv = 1'b0;
    m_ovr = 1'b0;
    m_idx = 4'd0;
  endfunction

  // Hold a code valid for on_cycles clocks, then idle long enough to release
  task automatic press_code(input logic [11:0] code, input int on_cycles, input bit rdy);
    @(negedge clk);
    key_code = code;
    key_valid = 1'b1;
    frame_ready = rdy;
    repeat (on_cycles - 1) @(negedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    key_code = 12'd0;
    repeat (30) @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic press_key(input int idx, input bit rdy);
    logic [11:0] one;
    one = 12'b1 << idx;
    press_code(one, 10, rdy);
    model_key(idx, rdy);
    if (rdy) m_fv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({grid, frame, frame_valid, key_event, key_idx, overrun} !== 25'd0) begin
      fails++;
      $display("[TB] FAIL reset_values: got grid=%h frame=%h fv=%b ev=%b idx=%0d ovr=%b, expected all zero",
               grid, frame, frame_valid, key_event, key_idx, overrun);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_toggle();
    int e0;
    int lat;
    bit seen;
    e0 = ev_cnt;
    lat = 0;
    seen = 1'b0;
    @(negedge clk);
    key_code = 12'h001;
    key_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (key_event && !seen) begin
        seen = 1'b1;
        lat = i;
      end
    end
    @(negedge clk);
    key_valid = 1'b0;
    key_code = 12'd0;
    repeat (30) @(negedge clk);
    model_key(0, 1'b0);
    tests++;
    if (!seen || lat != 7) begin
      fails++;
      $display("[TB] FAIL basic_latency: seen=%b after %0d edges, expected 7", seen, lat);
    end
    tests++;
    if (grid !== m_grid) begin
      fails++;
      $display("[TB] FAIL basic_grid: got %h expected %h", grid, m_grid);
    end
    tests++;
    if (ev_cnt - e0 != 1) begin
      fails++;
      $display("[TB] FAIL basic_events: got %0d expected 1", ev_cnt - e0);
    end
    tests++;
    if (key_idx !== 4'd0) begin
      fails++;
      $display("[TB] FAIL basic_idx: got %0d expected 0", key_idx);
    end
  endtask

  task automatic test_held_key();
    int e0;
    e0 = ev_cnt;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      key_code = 12'h010;
      key_valid = 1'b1;
      repeat (5) @(negedge clk);
      key_valid = 1'b0;
      repeat (11) @(negedge clk);
    end
    key_code = 12'd0;
    repeat (30) @(negedge clk);
    model_key(4, 1'b0);
    tests++;
    if (grid !== m_grid) begin
      fails++;
      $display("[TB] FAIL held_grid: got %h expected %h", grid, m_grid);
    end
    tests++;
    if (ev_cnt - e0 != 1) begin
      fails++;
      $display("[TB] FAIL held_events: got %0d expected 1", ev_cnt - e0);
    end
    tests++;
    if (key_idx !== 4'd4) begin
      fails++;
      $display("[TB] FAIL held_idx: got %0d expected 4", key_idx);
    end
  endtask

  task automatic test_bounce();
    int e0;
    e0 = ev_cnt;
    press_code(12'h100, 3, 1'b0);
    tests++;
    if (ev_cnt != e0 || grid !== m_grid) begin
      fails++;
      $display("[TB] FAIL bounce_reject: events=%0d grid=%h expected 0 events grid=%h", ev_cnt - e0, grid, m_grid);
    end
    press_code(12'h003, 10, 1'b0);
    tests++;
    if (ev_cnt != e0 || grid !== m_grid) begin
      fails++;
      $display("[TB] FAIL multihot_reject: events=%0d grid=%h expected 0 events grid=%h", ev_cnt - e0, grid, m_grid);
    end
  endtask

  task automatic test_clear_submit();
    press_key(9, 1'b0);
    for (int k = 0; k < 9; k += 2) press_key(k, 1'b0);
    tests++;
    if (grid !== 9'h155) begin
      fails++;
      $display("[TB] FAIL build_155: got %h expected 155", grid);
    end
    press_key(9, 1'b0);
    tests++;
    if (grid !== 9'h000) begin
      fails++;
      $display("[TB] FAIL star_clear: got %h expected 000", grid);
    end
    for (int k = 1; k < 9; k += 2) press_key(k, 1'b0);
    press_key(11, 1'b0);
    tests++;
    if (frame !== 9'h0AA || frame_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL submit: got frame=%h fv=%b expected 0aa/1", frame, frame_valid);
    end
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    m_fv = 1'b0;
    tests++;
    if (frame_valid !== 1'b0 || frame !== 9'h0AA) begin
      fails++;
      $display("[TB] FAIL handshake: got frame=%h fv=%b expected 0aa/0", frame, frame_valid);
    end
  endtask

  task automatic test_overrun();
    press_key(11, 1'b0);
    for (int k = 0; k < 9; k += 2) press_key(k, 1'b0);
    press_key(11, 1'b0);
    tests++;
    if (frame !== 9'h0AA || overrun !== 1'b1 || frame_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL overrun: got frame=%h ovr=%b fv=%b expected 0aa/1/1", frame, overrun, frame_valid);
    end
    // '#' accept lands on edge 7 after the key_valid rise; ready only then
    @(negedge clk);
    key_code = 12'h800;
    key_valid = 1'b1;
    repeat (6) @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    tests++;
    if (key_event !== 1'b1 || frame !== 9'h1FF || frame_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reload: got ev=%b frame=%h fv=%b expected 1/1ff/1", key_event, frame, frame_valid);
    end
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    key_code = 12'd0;
    repeat (30) @(negedge clk);
    model_key(11, 1'b1);
    tests++;
    if (frame !== m_frame || frame_valid !== m_fv || overrun !== m_ovr) begin
      fails++;
      $display("[TB] FAIL reload_hold: got frame=%h fv=%b ovr=%b expected %h/%b/%b",
               frame, frame_valid, overrun, m_frame, m_fv, m_ovr);
    end
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    m_fv = 1'b0;
  endtask

  task automatic test_reset_held();
    int e0;
    @(negedge clk);
    key_code = 12'h001;
    key_valid = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    tests++;
    if ({grid, frame, frame_valid, key_event, key_idx, overrun} !== 25'd0) begin
      fails++;
      $display("[TB] FAIL reset_held_clear: got grid=%h frame=%h fv=%b ev=%b idx=%0d ovr=%b, expected all zero",
               grid, frame, frame_valid, key_event, key_idx, overrun);
    end
    repeat (3) @(negedge clk);
    e0 = ev_cnt;
    rst = 1'b1;
    repeat (15) @(negedge clk);
    key_valid = 1'b0;
    key_code = 12'd0;
    repeat (30) @(negedge clk);
    model_key(0, 1'b0);
    tests++;
    if (ev_cnt - e0 != 1 || grid !== m_grid || key_idx !== m_idx) begin
      fails++;
      $display("[TB] FAIL reset_reaccept: events=%0d grid=%h idx=%0d expected 1/%h/%0d",
               ev_cnt - e0, grid, key_idx, m_grid, m_idx);
    end
  endtask

  task automatic test_random();
    int idx;
    int on_cycles;
    bit clean;
    bit rdy;
    int e0;
    logic [11:0] one;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 11);
      clean = ($urandom_range(0, 3) != 0);
      on_cycles = clean ? $urandom_range(6, 12) : $urandom_range(1, 4);
      rdy = $urandom_range(0, 1);
      one = 12'b1 << idx;
      e0 = ev_cnt;
      press_code(one, on_cycles, rdy);
      if (rdy) m_fv = 1'b0;
      if (clean) model_key(idx, rdy);
      if (rdy) m_fv = 1'b0;
      tests++;
      if (ev_cnt - e0 != (clean ? 1 : 0)) begin
        fails++;
        $display("[TB] FAIL rand_events[%0d]: got %0d expected %0d", n, ev_cnt - e0, clean ? 1 : 0);
      end
      tests++;
      if (grid !== m_grid || key_idx !== m_idx) begin
        fails++;
        $display("[TB] FAIL rand_grid[%0d]: got grid=%h idx=%0d expected %h/%0d", n, grid, key_idx, m_grid, m_idx);
      end
      tests++;
      if (frame !== m_frame || frame_valid !== m_fv || overrun !== m_ovr) begin
        fails++;
        $display("[TB] FAIL rand_frame[%0d]: got frame=%h fv=%b ovr=%b expected %h/%b/%b",
                 n, frame, frame_valid, overrun, m_frame, m_fv, m_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_toggle();
    test_held_key();
    test_bounce();
    test_clear_submit();
    test_overrun();
    test_reset_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
